// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types and default sizing for the icache/dcache RAM-port arbiter.
package mem_bus_arbiter_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, IGNT = 2'd1, DGNT = 2'd2} arb_state_t;
    typedef enum logic [1:0] {FREE = 2'd0, BUSY = 2'd1, ACCESS = 2'd2, ERROR = 2'd3} ramstate_t;
    localparam int BURST_LEN_DEF  = 2;
    localparam int STARVE_MAX_DEF = 4;
endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Bundle of cache-side and RAM-side signals seen by the arbiter.
interface mem_bus_arbiter_if;
    logic        iREN;
    logic [31:0] iaddr;
    logic        iwait;
    logic [31:0] iload;
    logic        dREN;
    logic        dWEN;
    logic [31:0] daddr;
    logic [31:0] dstore;
    logic        dwait;
    logic [31:0] dload;
    logic        ramREN;
    logic        ramWEN;
    logic [31:0] ramaddr;
    logic [31:0] ramstore;
    logic [31:0] ramload;
    logic [1:0]  ramstate;

    modport slave (
        input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
    );
    modport master (
        output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
    );
endinterface

// File: rtl/mem_bus_arbiter_starve_counter.sv
// Saturating count of consecutive dcache grants taken while the icache waits.
module arb_starve_counter #(
    parameter int MAX = 4
) (
    input  logic CLK,
    input  logic nRST,
    input  logic i_clr,
    input  logic i_inc,
    output logic o_at_max
);
    localparam int W = $clog2(MAX + 1);

    logic [W-1:0] r_cnt;

    always_ff @(posedge CLK) begin
        if (!nRST)
            r_cnt <= '0;
        else if (i_clr)
            r_cnt <= '0;
        else if (i_inc && (r_cnt != W'(MAX)))
            r_cnt <= r_cnt + 1'b1;
    end

    assign o_at_max = (r_cnt == W'(MAX));
endmodule

// File: rtl/mem_bus_arbiter.sv
// Single-port RAM arbiter: grants the icache or dcache for up to one block,
// with a one-cycle IDLE bubble between grants and bounded icache starvation.
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int BURST_LEN  = BURST_LEN_DEF,
    parameter int STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic             CLK,
    input  logic             nRST,
    mem_bus_arbiter_if.slave bus
);
    localparam int WCW = $clog2(BURST_LEN) + 1;

    arb_state_t     r_state, w_next;
    logic [WCW-1:0] r_word_cnt, w_word_cnt_nxt;
    logic           w_dreq, w_acc, w_last, w_at_max, w_starve_clr, w_starve_inc;
    logic           w_ram_ren, w_ram_wen, w_iwait, w_dwait;
    logic [31:0]    w_ram_addr, w_ram_store;

    assign w_dreq = bus.dREN | bus.dWEN;
    assign w_acc  = (bus.ramstate == ACCESS);
    assign w_last = (r_word_cnt == WCW'(BURST_LEN - 1));

    arb_starve_counter #(.MAX(STARVE_MAX)) u_starve (
        .CLK      (CLK),
        .nRST     (nRST),
        .i_clr    (w_starve_clr),
        .i_inc    (w_starve_inc),
        .o_at_max (w_at_max)
    );

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            r_state    <= IDLE;
            r_word_cnt <= '0;
        end else begin
            r_state    <= w_next;
            r_word_cnt <= w_word_cnt_nxt;
        end
    end

    // RAM enables follow the live request so a dropped request releases the port at once.
    always_comb begin
        w_next         = r_state;
        w_word_cnt_nxt = r_word_cnt;
        w_ram_ren      = 1'b0;
        w_ram_wen      = 1'b0;
        w_ram_addr     = '0;
        w_ram_store    = '0;
        w_iwait        = 1'b1;
        w_dwait        = 1'b1;
        w_starve_clr   = 1'b0;
        w_starve_inc   = 1'b0;
        case (r_state)
            IDLE: begin
                w_word_cnt_nxt = '0;
                if (w_dreq && !(bus.iREN && w_at_max)) begin
                    w_next       = DGNT;
                    w_starve_inc = bus.iREN;
                    w_starve_clr = !bus.iREN;
                end else if (bus.iREN) begin
                    w_next       = IGNT;
                    w_starve_clr = 1'b1;
                end
            end
            IGNT: begin
                w_ram_ren  = bus.iREN;
                w_ram_addr = bus.iaddr;
                w_iwait    = !w_acc;
                if (!bus.iREN) begin
                    w_next         = IDLE;
                    w_word_cnt_nxt = '0;
                end else if (w_acc) begin
                    if (w_last) begin
                        w_next         = IDLE;
                        w_word_cnt_nxt = '0;
                    end else begin
                        w_word_cnt_nxt = r_word_cnt + 1'b1;
                    end
                end
            end
            DGNT: begin
                w_ram_wen   = bus.dWEN;
                w_ram_ren   = bus.dREN & ~bus.dWEN;
                w_ram_addr  = bus.daddr;
                w_ram_store = bus.dstore;
                w_dwait     = !w_acc;
                if (!w_dreq) begin
                    w_next         = IDLE;
                    w_word_cnt_nxt = '0;
                end else if (w_acc) begin
                    if (w_last) begin
                        w_next         = IDLE;
                        w_word_cnt_nxt = '0;
                    end else begin
                        w_word_cnt_nxt = r_word_cnt + 1'b1;
                    end
                end
            end
            default: begin
                w_next         = IDLE;
                w_word_cnt_nxt = '0;
            end
        endcase
    end

    assign bus.ramREN   = w_ram_ren;
    assign bus.ramWEN   = w_ram_wen;
    assign bus.ramaddr  = w_ram_addr;
    assign bus.ramstore = w_ram_store;
    assign bus.iwait    = w_iwait;
    assign bus.dwait    = w_dwait;
    assign bus.iload    = bus.ramload;
    assign bus.dload    = bus.ramload;
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed and randomized checks of mem_bus_arbiter against a grant-level model.
module tb_mem_bus_arbiter;
    localparam int BL = 2;
    localparam int SM = 4;

    logic CLK = 1'b0;
    logic nRST;
    int   checks = 0;
    int   errors = 0;

    mem_bus_arbiter_if bus ();

    mem_bus_arbiter #(.BURST_LEN(BL), .STARVE_MAX(SM)) dut (
        .CLK  (CLK),
        .nRST (nRST),
        .bus  (bus)
    );

    always #5 CLK = ~CLK;

    // Model: who owns the port (0 none, 1 icache, 2 dcache), words done, starvation count.
    int m_own = 0;
    int m_words = 0;
    int m_starve = 0;
    int obs_kind = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic ir, input logic [31:0] ia, input logic dr, input logic dw,
                         input logic [31:0] da, input logic [31:0] ds, input logic [1:0] rs);
        bus.iREN = ir; bus.iaddr = ia; bus.dREN = dr; bus.dWEN = dw;
        bus.daddr = da; bus.dstore = ds; bus.ramstate = rs;
    endtask

    task automatic cyc();
        logic        e_ren, e_wen, e_iw, e_dw, acc, dreq;
        logic [31:0] e_addr, e_store;
        int          n_own, n_words, n_starve;
        bus.ramload = $urandom;
        @(negedge CLK);
        acc  = (bus.ramstate == 2'd2);
        dreq = bus.dREN | bus.dWEN;
        e_ren = 0; e_wen = 0; e_addr = 0; e_store = 0; e_iw = 1; e_dw = 1;
        if (m_own == 1) begin
            e_ren = bus.iREN; e_addr = bus.iaddr; e_iw = !acc;
        end else if (m_own == 2) begin
            e_wen = bus.dWEN; e_ren = bus.dREN && !bus.dWEN;
            e_addr = bus.daddr; e_store = bus.dstore; e_dw = !acc;
        end
        chk("ramREN",   32'(bus.ramREN), 32'(e_ren));
        chk("ramWEN",   32'(bus.ramWEN), 32'(e_wen));
        chk("ramaddr",  bus.ramaddr, e_addr);
        chk("ramstore", bus.ramstore, e_store);
        chk("iwait",    32'(bus.iwait), 32'(e_iw));
        chk("dwait",    32'(bus.dwait), 32'(e_dw));
        chk("iload",    bus.iload, bus.ramload);
        chk("dload",    bus.dload, bus.ramload);
        obs_kind = bus.ramWEN ? 2 : (bus.ramREN ? 1 : 0);
        n_own = m_own; n_words = m_words; n_starve = m_starve;
        if (!nRST) begin
            n_own = 0; n_words = 0; n_starve = 0;
        end else if (m_own == 0) begin
            n_words = 0;
            if (dreq && !(bus.iREN && m_starve == SM)) begin
                n_own = 2;
                n_starve = bus.iREN ? ((m_starve < SM) ? m_starve + 1 : SM) : 0;
            end else if (bus.iREN) begin
                n_own = 1; n_starve = 0;
            end
        end else begin
            if ((m_own == 1 && !bus.iREN) || (m_own == 2 && !dreq)) begin
                n_own = 0; n_words = 0;
            end else if (acc) begin
                n_words = m_words + 1;
                if (n_words == BL) begin
                    n_own = 0; n_words = 0;
                end
            end
        end
        @(posedge CLK);
        #1;
        m_own = n_own; m_words = n_words; m_starve = n_starve;
    endtask

    initial begin
        int cnt, dgr, d_after, seen_i, prev;
        bit ir, dr, dw;
        nRST = 1'b0;
        bus.ramload = 0;
        drive(0, 0, 0, 0, 0, 0, 2'd0);
        // Reset state
        cyc(); cyc();
        nRST = 1'b1;
        cyc();

        // Lone icache read with two BUSY cycles before ACCESS
        drive(1, 32'h40, 0, 0, 0, 0, 2'd1);
        cnt = 0;
        cyc();
        cyc(); cnt += (bus.iwait == 0) ? 1 : 0;
        cyc(); cnt += (bus.iwait == 0) ? 1 : 0;
        bus.ramstate = 2'd2;
        @(negedge CLK); cnt += (bus.iwait == 0) ? 1 : 0;
        chk("lone_ren_addr", bus.ramaddr, 32'h40);
        @(posedge CLK); #1;
        // consume the cycle observed above through the model path
        m_words = 1;
        bus.iREN = 0; bus.ramstate = 2'd0;
        @(negedge CLK); cnt += (bus.iwait == 0) ? 1 : 0;
        @(posedge CLK); #1;
        m_own = 0; m_words = 0;
        chk("lone_iwait_low_cycles", cnt, 1);
        cyc(); cyc();

        // Both request from IDLE: dcache block 0x80/0x84 first, then icache
        drive(1, 32'h100, 1, 0, 32'h80, 0, 2'd2);
        cyc();
        cyc();
        bus.daddr = 32'h84;
        cyc();
        bus.dREN = 0;
        cyc();
        chk("both_then_icache_addr", bus.ramaddr, 32'h100);
        cyc(); cyc();
        bus.iREN = 0;
        cyc(); cyc();

        // Simultaneous dREN/dWEN writes
        drive(0, 0, 1, 1, 32'h200, 32'hDEADBEEF, 2'd1);
        cyc(); cyc();
        chk("wr_store", bus.ramstore, 32'hDEADBEEF);
        bus.ramstate = 2'd2;
        cyc(); cyc();
        drive(0, 0, 0, 0, 0, 0, 2'd0);
        cyc(); cyc();

        // Continuous dump with icache waiting: four dcache grants, then icache
        drive(1, 32'h300, 0, 1, 32'h400, 32'h1234, 2'd2);
        dgr = 0; d_after = 0; seen_i = 0; prev = 0;
        for (int k = 0; k < 40; k++) begin
            bus.daddr = 32'h400 + 32'(k);
            cyc();
            if (prev == 0 && obs_kind == 2) begin
                if (seen_i != 0) d_after++; else dgr++;
            end
            if (prev == 0 && obs_kind == 1 && seen_i == 0) seen_i = 1;
            prev = obs_kind;
        end
        chk("starve_dgrants_before_i", dgr, SM);
        chk("starve_icache_granted", seen_i, 1);
        chk("starve_dcache_resumed", 32'(d_after > 0), 1);
        drive(0, 0, 0, 0, 0, 0, 2'd0);
        cyc(); cyc(); cyc(); cyc();

        // ERROR while dcache owns the port
        drive(0, 0, 1, 0, 32'h500, 0, 2'd3);
        cyc();
        cnt = 0;
        for (int k = 0; k < 5; k++) begin
            cyc();
            cnt += (bus.dwait == 1 && bus.ramREN == 1) ? 1 : 0;
        end
        chk("error_hold_cycles", cnt, 5);
        bus.ramstate = 2'd2;
        cyc(); cyc();
        drive(0, 0, 0, 0, 0, 0, 2'd0);
        cyc(); cyc();

        // Reset mid-block after word 0
        drive(1, 32'h600, 1, 0, 32'h700, 0, 2'd2);
        cyc(); cyc();
        bus.ramstate = 2'd1;
        nRST = 1'b0;
        cyc();
        nRST = 1'b1;
        @(negedge CLK);
        chk("rst_mid_ren", 32'(bus.ramREN), 0);
        chk("rst_mid_dwait", 32'(bus.dwait), 1);
        chk("rst_mid_addr", bus.ramaddr, 0);
        @(posedge CLK); #1;
        // model after the IDLE cycle: requests still up, starve was cleared by reset
        m_own = 2; m_words = 0; m_starve = 1;
        drive(0, 0, 0, 0, 0, 0, 2'd0);
        cyc(); cyc();

        // Randomized traffic
        ir = 0; dr = 0; dw = 0;
        for (int k = 0; k < 600; k++) begin
            if ($urandom_range(0, 3) == 0) ir = $urandom_range(0, 1);
            if ($urandom_range(0, 3) == 0) dr = $urandom_range(0, 1);
            if ($urandom_range(0, 3) == 0) dw = $urandom_range(0, 1);
            drive(ir, $urandom, dr, dw, $urandom, $urandom,
                  ($urandom_range(0, 9) < 6) ? 2'd2 : 2'($urandom_range(0, 3)));
            nRST = ($urandom_range(0, 99) != 0);
            cyc();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
